// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// field offsets, error codes, FSM states and register word builders.
package pll_reconfig_pkg;

    // Reconfig controller register addresses
    localparam logic [5:0] ADDR_MODE      = 6'h00;
    localparam logic [5:0] ADDR_STATUS    = 6'h01;
    localparam logic [5:0] ADDR_START     = 6'h02;
    localparam logic [5:0] ADDR_C_COUNTER = 6'h05;
    localparam logic [5:0] ADDR_PHASE     = 6'h06;

    // C-counter register fields
    localparam int unsigned CNT_SEL_LSB    = 18;
    localparam int unsigned CNT_ODD_BIT    = 17;
    localparam int unsigned CNT_BYPASS_BIT = 16;
    localparam int unsigned CNT_HI_LSB     = 8;
    localparam int unsigned CNT_LO_LSB     = 0;

    // Dynamic phase shift register fields
    localparam int unsigned PH_UP_BIT    = 21;
    localparam int unsigned PH_SEL_LSB   = 16;
    localparam int unsigned PH_STEPS_LSB = 0;

    // err_code encodings
    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_BAD_REQ      = 2'd1;
    localparam logic [1:0] ERR_POLL_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        WR_MODE,
        WR_CNT,
        WR_PHASE,
        WR_START,
        RD_STATUS,
        WAIT_LOCK,
        FIN
    } state_t;

    function automatic logic [31:0] cnt_word(
        input logic [4:0] sel,
        input logic       odd,
        input logic       bypass,
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        logic [31:0] w;
        w = '0;
        w[CNT_SEL_LSB +: 5]  = sel;
        w[CNT_ODD_BIT]       = odd;
        w[CNT_BYPASS_BIT]    = bypass;
        w[CNT_HI_LSB +: 8]   = hi;
        w[CNT_LO_LSB +: 8]   = lo;
        return w;
    endfunction

    function automatic logic [31:0] phase_word(
        input logic        up,
        input logic [4:0]  sel,
        input logic [15:0] steps
    );
        logic [31:0] w;
        w = '0;
        w[PH_UP_BIT]            = up;
        w[PH_SEL_LSB +: 5]      = sel;
        w[PH_STEPS_LSB +: 16]   = steps;
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Shift the raw lock through two flops; both clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Sequences one C-counter (and optional phase shift) reconfiguration of the
// PLL through its Avalon-MM reconfig controller, then qualifies re-lock.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned NUM_COUNTERS        = 6
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cnt_sel,
    input  logic [7:0]  req_hi,
    input  logic [7:0]  req_lo,
    input  logic        req_odd,
    input  logic        req_bypass,
    input  logic [15:0] req_phase_steps,
    input  logic        req_phase_up,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    state_t      state;
    logic [4:0]  cnt_sel;
    logic [7:0]  cnt_hi;
    logic [7:0]  cnt_lo;
    logic        cnt_odd;
    logic        cnt_bypass;
    logic [15:0] phase_steps;
    logic        phase_up;
    logic [31:0] stable_cnt;
    logic [31:0] lock_timer;
    logic [31:0] poll_cnt;
    logic        lock_sync;
    logic        bad_req;
    logic        unused_readdata;

    // Only the busy/done flag of the status word matters
    assign unused_readdata = ^mgmt_readdata[31:1];

    pll_lock_sync u_lock_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_sync)
    );

    // Latched request is rejected for an out-of-range counter or a zero count
    // on a non-bypassed counter
    always_comb begin
        bad_req = (32'(cnt_sel) >= NUM_COUNTERS) ||
                  (!cnt_bypass && ((cnt_hi == '0) || (cnt_lo == '0)));
    end

    // Main sequencer: bus accesses, status polling, lock qualification
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= ERR_NONE;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
            cnt_sel        <= '0;
            cnt_hi         <= '0;
            cnt_lo         <= '0;
            cnt_odd        <= 1'b0;
            cnt_bypass     <= 1'b0;
            phase_steps    <= '0;
            phase_up       <= 1'b0;
            stable_cnt     <= '0;
            lock_timer     <= '0;
            poll_cnt       <= '0;
        end else begin
            // Free-running saturating timer, re-armed when the start write completes
            if (lock_timer != '1) begin
                lock_timer <= lock_timer + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt_sel     <= req_cnt_sel;
                        cnt_hi      <= req_hi;
                        cnt_lo      <= req_lo;
                        cnt_odd     <= req_odd;
                        cnt_bypass  <= req_bypass;
                        phase_steps <= req_phase_steps;
                        phase_up    <= req_phase_up;
                        err_code    <= ERR_NONE;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CHECK;
                    end
                end

                CHECK: begin
                    if (bad_req) begin
                        error    <= 1'b1;
                        err_code <= ERR_BAD_REQ;
                        state    <= FIN;
                    end else begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= '0;
                        state          <= WR_MODE;
                    end
                end

                WR_MODE: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_address   <= ADDR_C_COUNTER;
                        mgmt_writedata <= cnt_word(cnt_sel, cnt_odd, cnt_bypass, cnt_hi, cnt_lo);
                        state          <= WR_CNT;
                    end
                end

                WR_CNT: begin
                    if (!mgmt_waitrequest) begin
                        if (phase_steps != '0) begin
                            mgmt_address   <= ADDR_PHASE;
                            mgmt_writedata <= phase_word(phase_up, cnt_sel, phase_steps);
                            state          <= WR_PHASE;
                        end else begin
                            mgmt_address   <= ADDR_START;
                            mgmt_writedata <= '0;
                            state          <= WR_START;
                        end
                    end
                end

                WR_PHASE: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_address   <= ADDR_START;
                        mgmt_writedata <= '0;
                        state          <= WR_START;
                    end
                end

                WR_START: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_write     <= 1'b0;
                        mgmt_read      <= 1'b1;
                        mgmt_address   <= ADDR_STATUS;
                        mgmt_writedata <= '0;
                        lock_timer     <= '0;
                        poll_cnt       <= '0;
                        state          <= RD_STATUS;
                    end
                end

                RD_STATUS: begin
                    // Read strobe stays high across polls: back-to-back reads
                    if (!mgmt_waitrequest) begin
                        if (mgmt_readdata[0]) begin
                            mgmt_read  <= 1'b0;
                            stable_cnt <= '0;
                            state      <= WAIT_LOCK;
                        end else if (poll_cnt >= LOCK_TIMEOUT_CYCLES) begin
                            mgmt_read <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_POLL_TIMEOUT;
                            state     <= FIN;
                        end else begin
                            poll_cnt <= poll_cnt + 32'd1;
                        end
                    end
                end

                WAIT_LOCK: begin
                    if (stable_cnt >= LOCK_STABLE_CYCLES) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (lock_timer >= LOCK_TIMEOUT_CYCLES) begin
                        error    <= 1'b1;
                        err_code <= ERR_LOCK_TIMEOUT;
                        state    <= FIN;
                    end else if (lock_sync) begin
                        stable_cnt <= stable_cnt + 32'd1;
                    end else begin
                        stable_cnt <= '0;
                    end
                end

                FIN: begin
                    done      <= 1'b0;
                    error     <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Randomized + directed scoreboard bench for pll_reconfig_sequencer.
`timescale 1ns/1ps
module tb_pll_reconfig_sequencer;

    localparam int unsigned STABLE = 16;
    localparam int unsigned TMO    = 100;
    localparam int unsigned NCNT   = 6;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [4:0]  sel;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        odd;
        logic        byp;
        logic [15:0] steps;
        logic        up;
    } req_t;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_cnt_sel = '0;
    logic [7:0]  req_hi = '0;
    logic [7:0]  req_lo = '0;
    logic        req_odd = 1'b0;
    logic        req_bypass = 1'b0;
    logic [15:0] req_phase_steps = '0;
    logic        req_phase_up = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    always #10 refclk = ~refclk;

    pll_reconfig_sequencer #(
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .NUM_COUNTERS        (NCNT)
    ) dut (
        .refclk           (refclk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cnt_sel      (req_cnt_sel),
        .req_hi           (req_hi),
        .req_lo           (req_lo),
        .req_odd          (req_odd),
        .req_bypass       (req_bypass),
        .req_phase_steps  (req_phase_steps),
        .req_phase_up     (req_phase_up),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // ---------------- Avalon slave model ----------------
    int unsigned held = 0;
    int unsigned rnd_stall = 0;
    int unsigned stall_max = 0;
    int unsigned force_cnt_stall = 0;
    int unsigned polls_before_ok = 0;
    logic        status_never = 1'b0;
    int unsigned reads_seen = 0;
    logic [31:0] stall_len;

    always_comb begin
        stall_len = rnd_stall;
        if (force_cnt_stall != 0 && mgmt_write && mgmt_address == 6'h05)
            stall_len = force_cnt_stall;
        mgmt_waitrequest = (mgmt_write || mgmt_read) && (held < stall_len);
        mgmt_readdata = {16'hBEEF, 15'h0, (!status_never && (reads_seen >= polls_before_ok))};
    end

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            held       <= 0;
            reads_seen <= 0;
        end else begin
            if (req_valid && req_ready) reads_seen <= 0;
            if (mgmt_write || mgmt_read) begin
                if (mgmt_waitrequest) begin
                    held <= held + 1;
                end else begin
                    held      <= 0;
                    rnd_stall <= $urandom_range(stall_max, 0);
                    if (mgmt_read) reads_seen <= reads_seen + 1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    ev_t         exp_q[$];
    int unsigned mon_reads = 0;
    logic [5:0]  last_rd_addr = '0;
    int unsigned n_end = 0;
    int unsigned accept_cyc = 0;
    int unsigned rd_ok_cyc = 0;
    int unsigned end_cyc = 0;
    int unsigned wr_cyc[$];

    task automatic observe(input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 0x%0h expected none", got);
        end else begin
            e = exp_q.pop_front();
            chk("scoreboard_event", 64'(got), 64'(e));
        end
    endtask

    always @(negedge refclk) begin
        if (rst) begin
            mon_reads = 0;
        end else begin
            if (req_valid && req_ready) begin
                accept_cyc = cyc;
                mon_reads = 0;
                wr_cyc.delete();
            end
            if (mgmt_write && !mgmt_waitrequest) begin
                wr_cyc.push_back(cyc);
                observe('{EV_WR, mgmt_address, mgmt_writedata});
            end
            if (mgmt_read && !mgmt_waitrequest) begin
                mon_reads++;
                last_rd_addr = mgmt_address;
                if (mgmt_readdata[0]) rd_ok_cyc = cyc;
            end
            if (done || error) begin
                if (mon_reads != 0) observe('{EV_RD, last_rd_addr, 32'(mon_reads)});
                if (done) observe('{EV_DONE, 6'h00, 32'h0});
                if (error) observe('{EV_ERR, 6'h00, 32'(err_code)});
                end_cyc = cyc;
                n_end++;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void push_expect(input req_t r, input int unsigned polls,
                                        input logic never, input logic lock_ok);
        if (32'(r.sel) >= NCNT || (!r.byp && (r.hi == 0 || r.lo == 0))) begin
            exp_q.push_back('{EV_ERR, 6'h00, 32'd1});
            return;
        end
        exp_q.push_back('{EV_WR, 6'h00, 32'h0});
        exp_q.push_back('{EV_WR, 6'h05, 32'(r.sel) * 32'd262144 + 32'(r.odd) * 32'd131072 +
                                        32'(r.byp) * 32'd65536 + 32'(r.hi) * 32'd256 + 32'(r.lo)});
        if (r.steps != 0)
            exp_q.push_back('{EV_WR, 6'h06, 32'(r.up) * 32'd2097152 + 32'(r.sel) * 32'd65536 +
                                            32'(r.steps)});
        exp_q.push_back('{EV_WR, 6'h02, 32'h0});
        if (never) begin
            exp_q.push_back('{EV_RD, 6'h01, 32'(TMO + 1)});
            exp_q.push_back('{EV_ERR, 6'h00, 32'd2});
        end else begin
            exp_q.push_back('{EV_RD, 6'h01, 32'(polls + 1)});
            if (lock_ok) exp_q.push_back('{EV_DONE, 6'h00, 32'h0});
            else         exp_q.push_back('{EV_ERR, 6'h00, 32'd3});
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    int unsigned end_base = 0;

    task automatic send(input req_t r, input int unsigned polls, input logic never,
                        input logic lock_ok, input int unsigned hold_extra);
        bit got;
        polls_before_ok = polls;
        status_never    = never;
        @(posedge refclk); #1;
        req_cnt_sel     = r.sel;
        req_hi          = r.hi;
        req_lo          = r.lo;
        req_odd         = r.odd;
        req_bypass      = r.byp;
        req_phase_steps = r.steps;
        req_phase_up    = r.up;
        req_valid       = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge refclk);
            if (req_ready) got = 1;
        end
        chk("request_accepted", 64'(got), 64'(1));
        end_base = n_end;
        push_expect(r, polls, never, lock_ok);
        @(posedge refclk); #1;
        if (hold_extra == 0) req_valid = 1'b0;
        @(negedge refclk);
        chk("ready_low_after_accept", 64'(req_ready), 64'(0));
        chk("err_clear_on_accept", 64'(err_code), 64'(0));
        if (hold_extra != 0) begin
            repeat (hold_extra) @(posedge refclk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_end(input int unsigned budget);
        bit seen;
        seen = 0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge refclk);
            if (n_end != end_base) seen = 1;
        end
        chk("transaction_end_within_budget", 64'(seen), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 64'({req_ready, busy, done, error, err_code, mgmt_write, mgmt_read,
                       mgmt_address, mgmt_writedata}), 64'({1'b1, 45'd0}));
    endtask

    // ---------------- test sequence ----------------
    req_t        base_req;
    req_t        r;
    int unsigned good;
    int unsigned rmark;
    int unsigned rise;
    bit          got_rd;

    initial begin
        base_req = '{sel: 5'd1, hi: 8'd30, lo: 8'd30, odd: 1'b0, byp: 1'b0, steps: 16'd0, up: 1'b0};

        repeat (3) @(posedge refclk);
        @(negedge refclk);
        chk_reset_outputs("reset_state");
        @(posedge refclk); #1 rst = 1'b0;
        pll_locked = 1'b1;
        repeat (4) @(posedge refclk);

        // zero-wait nominal: writes T+2..T+4, read T+5, done 18 after read
        send(base_req, 0, 1'b0, 1'b1, 0);
        wait_end(400);
        chk("nominal_write_count", 64'(wr_cyc.size()), 64'(3));
        if (wr_cyc.size() == 3) begin
            chk("nominal_w0_cycle", 64'(wr_cyc[0]), 64'(accept_cyc + 2));
            chk("nominal_w1_cycle", 64'(wr_cyc[1]), 64'(accept_cyc + 3));
            chk("nominal_w2_cycle", 64'(wr_cyc[2]), 64'(accept_cyc + 4));
        end
        chk("nominal_read_cycle", 64'(rd_ok_cyc), 64'(accept_cyc + 5));
        chk("nominal_done_cycle", 64'(end_cyc), 64'(rd_ok_cyc + 18));

        // phase write inserted; valid held high while busy must be ignored
        r = base_req;
        r.steps = 16'd20;
        r.up = 1'b1;
        send(r, 0, 1'b0, 1'b1, 4);
        wait_end(400);
        chk("phase_read_cycle", 64'(rd_ok_cyc), 64'(accept_cyc + 6));

        // bad requests: error at T+2, err_code held afterwards
        r = base_req;
        r.sel = 5'd6;
        send(r, 0, 1'b0, 1'b1, 0);
        wait_end(50);
        chk("bad_sel_error_cycle", 64'(end_cyc), 64'(accept_cyc + 2));
        repeat (3) @(negedge refclk);
        chk("bad_sel_err_code_held", 64'(err_code), 64'(1));
        r = base_req;
        r.hi = 8'd0;
        send(r, 0, 1'b0, 1'b1, 0);
        wait_end(50);
        chk("bad_hi_error_cycle", 64'(end_cyc), 64'(accept_cyc + 2));

        // waitrequest held 5 cycles on the C-counter write
        force_cnt_stall = 5;
        send(base_req, 0, 1'b0, 1'b1, 0);
        good = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge refclk);
            if (c >= 1 && c <= 6 && mgmt_write && mgmt_address == 6'h05 &&
                mgmt_writedata == 32'h00041E1E) good++;
        end
        chk("stall_hold_cycles", 64'(good), 64'(6));
        chk("stall_next_write", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'h02}));
        wait_end(400);
        force_cnt_stall = 0;

        // lock glitch after ~10 stable cycles; done 2 sync + 16 stable + 1 after rise
        send(base_req, 0, 1'b0, 1'b1, 0);
        got_rd = 0;
        rmark = 0;
        for (int i = 0; i < 300 && !got_rd; i++) begin
            @(negedge refclk);
            if (mgmt_read && !mgmt_waitrequest && mgmt_readdata[0]) begin
                got_rd = 1;
                rmark = cyc;
            end
        end
        chk("glitch_read_seen", 64'(got_rd), 64'(1));
        while (cyc < rmark + 10) @(negedge refclk);
        @(posedge refclk); #1 pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #1 pll_locked = 1'b1;
        rise = cyc;
        wait_end(400);
        chk("glitch_done_cycle", 64'(end_cyc), 64'(rise + 2 + STABLE + 1));

        // lock never arrives
        pll_locked = 1'b0;
        send(base_req, 1, 1'b0, 1'b0, 0);
        wait_end(400);
        repeat (2) @(negedge refclk);
        chk("lock_timeout_err_code", 64'(err_code), 64'(3));
        pll_locked = 1'b1;
        repeat (4) @(posedge refclk);

        // status never completes
        send(base_req, 0, 1'b1, 1'b1, 0);
        wait_end(600);
        chk("poll_timeout_err_code", 64'(err_code), 64'(2));

        // async reset in RD_STATUS aborts without done/error
        send(base_req, 0, 1'b1, 1'b1, 0);
        got_rd = 0;
        for (int i = 0; i < 100 && !got_rd; i++) begin
            @(negedge refclk);
            if (mgmt_read) got_rd = 1;
        end
        chk("reset_test_in_rd_status", 64'(got_rd), 64'(1));
        repeat (3) @(negedge refclk);
        #5 rst = 1'b1;
        #1 chk_reset_outputs("reset_async");
        exp_q.delete();
        repeat (2) @(posedge refclk);
        #1 rst = 1'b0;
        status_never = 1'b0;
        repeat (20) @(negedge refclk);
        chk_reset_outputs("idle_after_reset");
        send(base_req, 0, 1'b0, 1'b1, 0);
        wait_end(400);
        chk("post_reset_done_cycle", 64'(end_cyc), 64'(accept_cyc + 23));

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            r.sel   = 5'($urandom_range(7, 0));
            r.byp   = 1'($urandom_range(1, 0));
            r.hi    = ($urandom_range(5, 0) == 0) ? 8'd0 : 8'($urandom);
            r.lo    = ($urandom_range(5, 0) == 0) ? 8'd0 : 8'($urandom);
            r.odd   = 1'($urandom_range(1, 0));
            r.steps = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(65535, 1)) : 16'd0;
            r.up    = 1'($urandom_range(1, 0));
            stall_max = $urandom_range(2, 0);
            send(r, $urandom_range(4, 0), 1'b0, 1'b1, 0);
            wait_end(600);
        end

        repeat (5) @(negedge refclk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
